queue_param: RTL
================

Name: queue_param

Overview:
- Parametrised successor of the team's 8x8 shift-register queue.
- Circular-buffer FIFO with configurable data width and depth.
- Requests are edge-detected, so one operation happens per request assertion. Enqueue and dequeue may occur in the same cycle.
- Adds full/empty flags, a dequeue-valid strobe, sticky overflow/underflow flags and a synchronous clear.
- Sits between producer/consumer blocks in the 10 kHz clock domain.

Parameters:
- DATA_WIDTH, 8: bits per entry.
- DEPTH, 8: number of entries. Must be a power of two and at least 2.
- LEN_WIDTH, $clog2(DEPTH)+1: width of len_out. Holds 0..DEPTH.

Ports:
- clock_10KHZ  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  DATA_WIDTH  entry to enqueue.
- enqueue_in  input  1  enqueue request; acted on at its 0->1 transition.
- dequeue_in  input  1  dequeue request; acted on at its 0->1 transition.
- clear_in  input  1  synchronous flush, level-sensitive, active-high.
- data_out  output  DATA_WIDTH  last dequeued entry; held until the next dequeue.
- data_valid_out  output  1  one-cycle pulse when data_out is updated.
- len_out  output  LEN_WIDTH  current occupancy.
- full_out  output  1  high when len_out == DEPTH.
- empty_out  output  1  high when len_out == 0.
- overflow_out  output  1  sticky: an enqueue was dropped because the queue was full.
- underflow_out  output  1  sticky: a dequeue was dropped because the queue was empty.

Behaviour:
- Reset (reset low, asynchronous):
  - Clears read/write pointers, len_out, data_out, data_valid_out, overflow_out, underflow_out and both request-history registers.
  - empty_out = 1, full_out = 0. Storage contents are not reset.
- Edge detection:
  - enq_evt = enqueue_in & ~enq_prev; deq_evt = dequeue_in & ~deq_prev.
  - The prev registers sample the inputs every cycle.
  - A request held high for N cycles yields exactly one event.
- Enqueue event, not full:
  - mem[wr_ptr] <= data_in; wr_ptr increments modulo DEPTH.
- Dequeue event, not empty:
  - data_out <= mem[rd_ptr]; rd_ptr increments modulo DEPTH; data_valid_out = 1 for that cycle only.
  - Latency: data_out is valid on the clock edge that samples the rising dequeue_in.
- Occupancy: len_out changes by +1, -1 or 0 per cycle according to which operations were accepted.
- Simultaneous enqueue and dequeue events:
  - Not empty, including full: both are accepted. The dequeue reads the oldest entry; the enqueue writes the new one; len_out is unchanged.
  - Empty: the enqueue is accepted, the dequeue is rejected and sets underflow_out. There is no pass-through.
- Rejections:
  - Enqueue event while full, without a simultaneous dequeue: data dropped, overflow_out <= 1, state otherwise unchanged.
  - Dequeue event while empty: underflow_out <= 1; data_out and data_valid_out unchanged (no pulse).
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from len_out, never from pointer equality.
- clear_in high:
  - Takes priority over all events that cycle: pointers and len_out to 0; overflow_out and underflow_out to 0; data_valid_out to 0.
  - data_out is held. The prev registers still update, so a request held across clear is not re-triggered.
- Reset mid-operation: the asynchronous reset wins immediately. A request still high after reset release does not generate an event until it returns low and rises again.
- Outputs are registered, except full_out and empty_out, which are decoded combinationally from the registered len_out.

Test Plan:
- Fill/drain, DEPTH=8: enqueue 0x11..0x88 with eight separate pulses. Expect len_out=8 and full_out=1. Eight dequeue pulses return 0x11..0x88 in order, each with a one-cycle data_valid_out; then len_out=0, empty_out=1.
- Held request: enqueue_in high for 5 cycles with data_in=0xA5. Expect exactly one write and len_out=1. A dequeue then returns 0xA5.
- Overflow: with the queue full, pulse enqueue with 0xFF. Expect overflow_out=1, len_out stays 8, and drained data contains no 0xFF. A clear_in pulse then gives len_out=0, overflow_out=0, empty_out=1.
- Underflow and simultaneous ops on empty: with the queue empty, a dequeue pulse gives underflow_out=1 and no data_valid_out. Simultaneous rising enqueue(0x3C)/dequeue on empty gives len_out=1, then a later dequeue returns 0x3C.
- Simultaneous ops on full, with wrap: fill with 1..8, dequeue 3, enqueue 3 so the pointers wrap. Then pulse both with data_in=0x99. Expect data_out=4 and len_out stays 8; the full drain yields 5,6,7,8,9,10,11,0x99.
- Asynchronous reset: assert reset low mid-clock-cycle with len_out=5 and enqueue_in held high. Expect all outputs at reset values immediately. After release with enqueue_in still high, there is no enqueue until enqueue_in returns low and rises again.

Source files
------------

// File: rtl/queue_param.sv
// queue_param: parametrised circular-buffer FIFO with edge-detected requests,
// full/empty/len status, sticky overflow/underflow flags and synchronous clear.
module queue_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int LEN_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clock_10KHZ,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  enqueue_in,
    input  logic                  dequeue_in,
    input  logic                  clear_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid_out,
    output logic [LEN_WIDTH-1:0]  len_out,
    output logic                  full_out,
    output logic                  empty_out,
    output logic                  overflow_out,
    output logic                  underflow_out
);

    localparam int PTR_WIDTH = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic                  enq_prev;
    logic                  deq_prev;
    // Low for the first cycle after reset so a request still held high
    // across reset release is absorbed into the history registers.
    logic                  armed;
    logic                  enq_evt;
    logic                  deq_evt;
    logic                  enq_ok;
    logic                  deq_ok;

    // Status decode and request acceptance from registered occupancy.
    always_comb begin
        full_out  = (len_out == LEN_WIDTH'(DEPTH));
        empty_out = (len_out == '0);
        enq_evt   = enqueue_in & ~enq_prev & armed;
        deq_evt   = dequeue_in & ~deq_prev & armed;
        deq_ok    = deq_evt & ~empty_out;
        enq_ok    = enq_evt & (~full_out | deq_ok);
    end

    // Storage write port; contents are intentionally not reset.
    always_ff @(posedge clock_10KHZ) begin
        if (reset && !clear_in && enq_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy, read data, flags and request history.
    always_ff @(posedge clock_10KHZ or negedge reset) begin
        if (!reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            len_out        <= '0;
            data_out       <= '0;
            data_valid_out <= 1'b0;
            overflow_out   <= 1'b0;
            underflow_out  <= 1'b0;
            enq_prev       <= 1'b0;
            deq_prev       <= 1'b0;
            armed          <= 1'b0;
        end else begin
            enq_prev <= enqueue_in;
            deq_prev <= dequeue_in;
            armed    <= 1'b1;
            if (clear_in) begin
                wr_ptr         <= '0;
                rd_ptr         <= '0;
                len_out        <= '0;
                data_valid_out <= 1'b0;
                overflow_out   <= 1'b0;
                underflow_out  <= 1'b0;
            end else begin
                data_valid_out <= deq_ok;
                if (enq_ok) begin
                    wr_ptr <= wr_ptr + PTR_WIDTH'(1);
                end
                if (deq_ok) begin
                    data_out <= mem[rd_ptr];
                    rd_ptr   <= rd_ptr + PTR_WIDTH'(1);
                end
                if (enq_evt && !enq_ok) begin
                    overflow_out <= 1'b1;
                end
                if (deq_evt && !deq_ok) begin
                    underflow_out <= 1'b1;
                end
                case ({enq_ok, deq_ok})
                    2'b10:   len_out <= len_out + LEN_WIDTH'(1);
                    2'b01:   len_out <= len_out - LEN_WIDTH'(1);
                    default: len_out <= len_out;
                endcase
            end
        end
    end

endmodule
